// File: rtl/kmkz_defs.sv
// -----------------------------------------------------------------------------
// kmkz_defs
// Shared encodings used across the pipeline:
//   LDST_*      : load/store width and signedness carried in the fun field
//   RD_SOURCE_* : selects which execute-stage result feeds the rd write
// -----------------------------------------------------------------------------
package kmkz_defs;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_L  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic [2:0] RD_SOURCE_ALU      = 3'd0;
  localparam logic [2:0] RD_SOURCE_SHIFTER  = 3'd1;
  localparam logic [2:0] RD_SOURCE_MULTIPLY = 3'd2;
  localparam logic [2:0] RD_SOURCE_DIVIDE   = 3'd3;
  localparam logic [2:0] RD_SOURCE_CSR      = 3'd4;

endpackage

// File: rtl/urv_writeback_if.sv
// -----------------------------------------------------------------------------
// urv_writeback_if
// AHB-Lite data-phase response signals seen by the writeback stage.
//   HRDATA : read data, meaningful only while HREADY=1
//   HREADY : 1 = the current data phase completes this cycle
//   HRESP  : 1 = error response (taken together with HREADY=1)
// Handshake: a data phase is open from the cycle the access is presented until
// the first cycle with HREADY=1; HRDATA/HRESP are sampled only on that cycle
// and are don't-care at every other time.
// Modports:
//   master : the CPU side (writeback), receives the response
//   slave  : the bus/memory side, drives the response
// -----------------------------------------------------------------------------
interface urv_writeback_if;

  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (input HRDATA, HREADY, HRESP);
  modport slave  (output HRDATA, HREADY, HRESP);

endinterface

// File: rtl/urv_load_align.sv
// -----------------------------------------------------------------------------
// urv_load_align
// Combinational extraction of a load result from a 32-bit bus word.
//   fun_i   : LDST_* width/signedness code
//   addr_i  : low two address bits (byte lane / halfword select)
//   data_i  : raw 32-bit bus word
//   value_o : extended load result
// -----------------------------------------------------------------------------
module urv_load_align
  import kmkz_defs::*;
(
  input  logic [2:0]  fun_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
  end

  assign half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    value_o = data_i;
    case (fun_i)
      LDST_B:  value_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: value_o = {24'h0, byte_sel};
      LDST_H:  value_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: value_o = {16'h0, half_sel};
      default: value_o = data_i;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// -----------------------------------------------------------------------------
// urv_writeback
// Writeback stage: completes the AHB-Lite data phase of loads/stores, selects
// the rd result and drives the register-file write port, plus a one-cycle
// delayed copy of that write for the execute-stage bypass.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   w_stall_i            : global pipeline stall
//   w_stall_req_o        : stall request while the data phase waits on HREADY
//   w_* (inputs)         : registered X/W fields and execute results
//   ahb                  : data-phase response (HRDATA/HREADY/HRESP)
//   rf_rd_*_o            : register-file write port (combinational)
//   x_fwd_*_o            : registered copy of the last rf write
//   w_bus_error_o        : one pulse per erroring load/store transfer
//   dbg_state_o          : current data-phase FSM state
// -----------------------------------------------------------------------------
module urv_writeback
  import kmkz_defs::*;
(
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        w_stall_i,
  output logic        w_stall_req_o,

  input  logic        w_valid_i,
  input  logic        w_load_i,
  input  logic        w_store_i,
  input  logic [2:0]  w_fun_i,
  input  logic [4:0]  w_rd_i,
  input  logic        w_rd_write_i,
  input  logic [2:0]  w_rd_source_i,
  input  logic [31:0] w_dm_addr_i,

  input  logic [31:0] w_rd_value_i,
  input  logic [31:0] w_rd_shifter_i,
  input  logic [31:0] w_rd_multiply_i,

  urv_writeback_if.master ahb,

  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,

  output logic [4:0]  x_fwd_rd_o,
  output logic [31:0] x_fwd_value_o,
  output logic        x_fwd_valid_o,

  output logic        w_bus_error_o,
  output logic [1:0]  dbg_state_o
);

  // IDLE: no transfer outstanding (a new one may start this cycle)
  // WAIT: data phase open, slave still inserting wait states
  // HELD: data phase finished while the pipeline was stalled; response kept
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        hold_err_q, hold_err_d;

  logic [4:0]  fwd_rd_q, fwd_rd_d;
  logic [31:0] fwd_value_q, fwd_value_d;
  logic        fwd_valid_q, fwd_valid_d;

  logic        access_new;
  logic        in_dphase;
  logic        beat_done;
  logic        load_ok;
  logic [31:0] load_src;
  logic [31:0] load_value;
  logic [31:0] result;
  logic        unused_addr;

  assign unused_addr = ^w_dm_addr_i[31:2];

  assign access_new = w_valid_i & (w_load_i | w_store_i);

  // Outputs are gated by rst_i so they sit at their reset values while the
  // asynchronous reset is asserted, regardless of the incoming fields.
  assign in_dphase = rst_i & (((state_q == ST_IDLE) & access_new) |
                              (state_q == ST_WAIT));
  assign beat_done = in_dphase & ahb.HREADY;

  // Stores share the FSM so a stalled erroring store still pulses only once.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    case (state_q)
      ST_IDLE: begin
        if (access_new) begin
          if (!ahb.HREADY) begin
            state_d = ST_WAIT;
          end else if (w_stall_i) begin
            state_d     = ST_HELD;
            hold_data_d = ahb.HRDATA;
            hold_err_d  = ahb.HRESP;
          end
        end
      end
      ST_WAIT: begin
        if (ahb.HREADY) begin
          if (w_stall_i) begin
            state_d     = ST_HELD;
            hold_data_d = ahb.HRDATA;
            hold_err_d  = ahb.HRESP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HELD: begin
        if (!w_stall_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      hold_data_q <= 32'h0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
    end
  end

  // Once the beat has been captured, the bus is no longer looked at.
  assign load_src = (state_q == ST_HELD) ? hold_data_q : ahb.HRDATA;

  urv_load_align u_load_align (
    .fun_i   (w_fun_i),
    .addr_i  (w_dm_addr_i[1:0]),
    .data_i  (load_src),
    .value_o (load_value)
  );

  always_comb begin
    result = w_rd_value_i;
    if (w_load_i) begin
      result = load_value;
    end else if (w_rd_source_i == RD_SOURCE_SHIFTER) begin
      result = w_rd_shifter_i;
    end else if (w_rd_source_i == RD_SOURCE_MULTIPLY) begin
      result = w_rd_multiply_i;
    end
  end

  assign load_ok = (beat_done & ~ahb.HRESP) |
                   (rst_i & (state_q == ST_HELD) & ~hold_err_q);

  assign rf_rd_o       = w_rd_i;
  assign rf_rd_value_o = result;
  assign rf_rd_write_o = rst_i & w_rd_write_i & ~w_stall_i & (w_rd_i != 5'd0) &
                         ~w_store_i & (~w_load_i | load_ok);

  assign w_stall_req_o = in_dphase & ~ahb.HREADY;
  assign w_bus_error_o = beat_done & ahb.HRESP;

  always_comb begin
    fwd_rd_d    = fwd_rd_q;
    fwd_value_d = fwd_value_q;
    fwd_valid_d = 1'b0;
    if (rf_rd_write_o) begin
      fwd_rd_d    = w_rd_i;
      fwd_value_d = result;
      fwd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fwd_rd_q    <= 5'd0;
      fwd_value_q <= 32'h0;
      fwd_valid_q <= 1'b0;
    end else begin
      fwd_rd_q    <= fwd_rd_d;
      fwd_value_q <= fwd_value_d;
      fwd_valid_q <= fwd_valid_d;
    end
  end

  assign x_fwd_rd_o    = fwd_rd_q;
  assign x_fwd_value_o = fwd_value_q;
  assign x_fwd_valid_o = fwd_valid_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_urv_writeback.sv
// -----------------------------------------------------------------------------
// tb_urv_writeback
// Instruction-level bench: each instruction is described by its kind, result,
// bus wait states, stall length and error flag; the expected outputs of every
// cycle follow from those parameters and are queued for a single compare
// process that runs on the falling edge.
// -----------------------------------------------------------------------------
module tb_urv_writeback;
  import kmkz_defs::*;

  localparam int K_ALU = 0, K_SHIFT = 1, K_MUL = 2, K_LOAD = 3, K_STORE = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic        w_stall_i, w_stall_req_o;
  logic        w_valid_i, w_load_i, w_store_i;
  logic [2:0]  w_fun_i, w_rd_source_i;
  logic [4:0]  w_rd_i;
  logic        w_rd_write_i;
  logic [31:0] w_dm_addr_i, w_rd_value_i, w_rd_shifter_i, w_rd_multiply_i;
  logic [4:0]  rf_rd_o, x_fwd_rd_o;
  logic [31:0] rf_rd_value_o, x_fwd_value_o;
  logic        rf_rd_write_o, x_fwd_valid_o, w_bus_error_o;
  logic [1:0]  dbg_state_o;

  urv_writeback_if ahb_if ();

  urv_writeback dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .w_stall_i       (w_stall_i),
    .w_stall_req_o   (w_stall_req_o),
    .w_valid_i       (w_valid_i),
    .w_load_i        (w_load_i),
    .w_store_i       (w_store_i),
    .w_fun_i         (w_fun_i),
    .w_rd_i          (w_rd_i),
    .w_rd_write_i    (w_rd_write_i),
    .w_rd_source_i   (w_rd_source_i),
    .w_dm_addr_i     (w_dm_addr_i),
    .w_rd_value_i    (w_rd_value_i),
    .w_rd_shifter_i  (w_rd_shifter_i),
    .w_rd_multiply_i (w_rd_multiply_i),
    .ahb             (ahb_if),
    .rf_rd_o         (rf_rd_o),
    .rf_rd_value_o   (rf_rd_value_o),
    .rf_rd_write_o   (rf_rd_write_o),
    .x_fwd_rd_o      (x_fwd_rd_o),
    .x_fwd_value_o   (x_fwd_value_o),
    .x_fwd_valid_o   (x_fwd_valid_o),
    .w_bus_error_o   (w_bus_error_o),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {stall_req, write, bus_error, rd[4:0], value[31:0]}
  logic [39:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the bus word, by plain shifts and range tests.
  function automatic logic [31:0] model_load(input logic [2:0] fun, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = a[1] ? (d >> 16) : (d & 32'hFFFF);
    case (fun)
      LDST_B:  return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
      LDST_BU: return b;
      LDST_H:  return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
      LDST_HU: return h;
      default: return d;
    endcase
  endfunction

  task automatic push_exp(input logic sreq, input logic wr, input logic err,
                          input logic [4:0] rd, input logic [31:0] val);
    exp_q.push_back({sreq, wr, err, rd, val});
  endtask

  // ---------------- compare process ----------------
  logic        cmp_prev_w = 1'b0;
  logic [4:0]  cmp_prev_rd = 5'd0;
  logic [31:0] cmp_prev_val = 32'h0;
  logic [39:0] cmp_e;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        cmp_prev_w = 1'b0;
      end else if (exp_q.size() > 0) begin
        cmp_e = exp_q.pop_front();
        check("stall_req", 32'(w_stall_req_o), 32'(cmp_e[39]));
        check("rf_write", 32'(rf_rd_write_o), 32'(cmp_e[38]));
        check("bus_error", 32'(w_bus_error_o), 32'(cmp_e[37]));
        if (cmp_e[38]) begin
          check("rf_rd", 32'(rf_rd_o), 32'(cmp_e[36:32]));
          check("rf_value", rf_rd_value_o, cmp_e[31:0]);
        end
        check("fwd_valid", 32'(x_fwd_valid_o), 32'(cmp_prev_w));
        if (cmp_prev_w) begin
          check("fwd_rd", 32'(x_fwd_rd_o), 32'(cmp_prev_rd));
          check("fwd_value", x_fwd_value_o, cmp_prev_val);
        end
        cmp_prev_w   = cmp_e[38];
        cmp_prev_rd  = cmp_e[36:32];
        cmp_prev_val = cmp_e[31:0];
      end else begin
        cmp_prev_w = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    w_stall_i = 1'b0; w_valid_i = 1'b0; w_load_i = 1'b0; w_store_i = 1'b0;
    w_fun_i = 3'd0; w_rd_i = 5'd0; w_rd_write_i = 1'b0; w_rd_source_i = 3'd0;
    w_dm_addr_i = 32'h0; w_rd_value_i = 32'h0; w_rd_shifter_i = 32'h0;
    w_rd_multiply_i = 32'h0;
  endtask

  task automatic idle_cycle(input logic hready, input logic hresp);
    @(posedge clk_i); #1;
    set_idle();
    ahb_if.HREADY = hready;
    ahb_if.HRESP  = hresp;
    ahb_if.HRDATA = $urandom;
    push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  // One instruction: n_wait cycles of HREADY=0 (accesses only), then the
  // completing beat with stall held for n_stall cycles, then the retire cycle.
  task automatic run_instr(input int kind, input logic [4:0] rd, input logic rd_write,
                           input logic [2:0] fun, input logic [31:0] addr,
                           input logic [31:0] data, input int n_wait, input int n_stall,
                           input logic err);
    int          total;
    int          nw;
    logic        access;
    logic        wr;
    logic [31:0] val;
    access = (kind == K_LOAD) || (kind == K_STORE);
    nw     = access ? n_wait : 0;
    total  = nw + n_stall + 1;
    val    = (kind == K_LOAD) ? model_load(fun, addr[1:0], data) : data;
    wr     = rd_write && (rd != 5'd0) && (kind != K_STORE) && !(kind == K_LOAD && err);
    for (int c = 0; c < total; c++) begin
      @(posedge clk_i); #1;
      if (c == 0) begin
        w_valid_i = 1'b1; w_load_i = (kind == K_LOAD); w_store_i = (kind == K_STORE);
        w_fun_i = fun; w_rd_i = rd; w_rd_write_i = rd_write; w_dm_addr_i = addr;
        w_rd_value_i = $urandom; w_rd_shifter_i = $urandom; w_rd_multiply_i = $urandom;
        w_rd_source_i = 3'($urandom_range(0, 4));
        case (kind)
          K_ALU: begin
            case ($urandom_range(0, 2))
              0: w_rd_source_i = RD_SOURCE_ALU;
              1: w_rd_source_i = RD_SOURCE_DIVIDE;
              default: w_rd_source_i = RD_SOURCE_CSR;
            endcase
            w_rd_value_i = data;
          end
          K_SHIFT: begin w_rd_source_i = RD_SOURCE_SHIFTER;  w_rd_shifter_i  = data; end
          K_MUL:   begin w_rd_source_i = RD_SOURCE_MULTIPLY; w_rd_multiply_i = data; end
          default: ;
        endcase
      end
      if (access && c < nw) begin
        ahb_if.HREADY = 1'b0; ahb_if.HRDATA = $urandom; ahb_if.HRESP = 1'($urandom);
        w_stall_i = 1'($urandom);
      end else if (access && c == nw) begin
        ahb_if.HREADY = 1'b1; ahb_if.HRDATA = data; ahb_if.HRESP = err;
        w_stall_i = (n_stall > 0);
      end else begin
        ahb_if.HREADY = 1'($urandom); ahb_if.HRDATA = $urandom; ahb_if.HRESP = 1'($urandom);
        w_stall_i = (c < nw + n_stall);
      end
      push_exp(access && c < nw, wr && c == total - 1, access && err && c == nw, rd, val);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset with an active load presented: outputs must still be quiet.
    rst_i = 1'b0;
    set_idle();
    w_valid_i = 1'b1; w_load_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd3;
    ahb_if.HREADY = 1'b0; ahb_if.HRESP = 1'b1; ahb_if.HRDATA = 32'h0;
    repeat (2) @(negedge clk_i);
    check("rst_stall_req", 32'(w_stall_req_o), 32'd0);
    check("rst_rf_write", 32'(rf_rd_write_o), 32'd0);
    check("rst_bus_error", 32'(w_bus_error_o), 32'd0);
    check("rst_fwd_valid", 32'(x_fwd_valid_o), 32'd0);
    check("rst_fwd_rd", 32'(x_fwd_rd_o), 32'd0);
    check("rst_fwd_value", x_fwd_value_o, 32'h0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    @(posedge clk_i); #1;
    set_idle();
    ahb_if.HREADY = 1'b1; ahb_if.HRESP = 1'b0;
    rst_i = 1'b1;

    // Pin the load model with hand-computed values.
    check("model_lb", model_load(LDST_B, 2'd3, 32'h80FF1234), 32'hFFFFFF80);
    check("model_lbu", model_load(LDST_BU, 2'd3, 32'h80FF1234), 32'h00000080);
    check("model_lh", model_load(LDST_H, 2'd2, 32'h80FF1234), 32'hFFFF80FF);
    check("model_lhu", model_load(LDST_HU, 2'd0, 32'h80FF1234), 32'h00001234);

    // Signed / unsigned byte at lane 3, zero-latency write.
    run_instr(K_LOAD, 5'd7, 1'b1, LDST_B, 32'h2003, 32'h80FF1234, 0, 0, 1'b0);
    @(negedge clk_i);
    check("lb_value", rf_rd_value_o, 32'hFFFFFF80);
    check("lb_write", 32'(rf_rd_write_o), 32'd1);
    run_instr(K_LOAD, 5'd7, 1'b1, LDST_BU, 32'h2003, 32'h80FF1234, 0, 0, 1'b0);
    @(negedge clk_i);
    check("lbu_value", rf_rd_value_o, 32'h00000080);

    // Halfword load with three wait states.
    run_instr(K_LOAD, 5'd9, 1'b1, LDST_H, 32'h1002, 32'h80017FFF, 3, 0, 1'b0);
    @(negedge clk_i);
    check("lh_wait_value", rf_rd_value_o, 32'hFFFF8001);

    // Beat arrives during a 2-cycle stall; bus data changes afterwards.
    run_instr(K_LOAD, 5'd10, 1'b1, LDST_L, 32'h100, 32'hDEADBEEF, 0, 2, 1'b0);
    @(negedge clk_i);
    check("held_value", rf_rd_value_o, 32'hDEADBEEF);
    check("held_write", 32'(rf_rd_write_o), 32'd1);

    // Error responses, plain and stalled.
    run_instr(K_LOAD, 5'd11, 1'b1, LDST_L, 32'h0, 32'h12345678, 1, 0, 1'b1);
    run_instr(K_LOAD, 5'd11, 1'b1, LDST_L, 32'h0, 32'h12345678, 0, 2, 1'b1);
    run_instr(K_STORE, 5'd0, 1'b0, LDST_L, 32'h40, 32'h0, 2, 1, 1'b1);

    // Forwarding of an ALU write, and no write/forward for x0.
    run_instr(K_ALU, 5'd5, 1'b1, 3'd0, 32'h0, 32'h1234, 0, 0, 1'b0);
    idle_cycle(1'b1, 1'b0);
    @(negedge clk_i);
    check("fwd5_valid", 32'(x_fwd_valid_o), 32'd1);
    check("fwd5_rd", 32'(x_fwd_rd_o), 32'd5);
    check("fwd5_value", x_fwd_value_o, 32'h1234);
    run_instr(K_ALU, 5'd0, 1'b1, 3'd0, 32'h0, 32'h5555, 0, 0, 1'b0);
    @(negedge clk_i);
    check("x0_write", 32'(rf_rd_write_o), 32'd0);
    idle_cycle(1'b1, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      logic [2:0] fun;
      case ($urandom_range(0, 4))
        0: fun = LDST_B;
        1: fun = LDST_H;
        2: fun = LDST_L;
        3: fun = LDST_BU;
        default: fun = LDST_HU;
      endcase
      run_instr($urandom_range(0, 4), 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                fun, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 7) == 0) idle_cycle(1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a waiting load.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i); #1;
      w_valid_i = 1'b1; w_load_i = 1'b1; w_store_i = 1'b0; w_fun_i = LDST_L;
      w_rd_i = 5'd12; w_rd_write_i = 1'b1; w_stall_i = 1'b0;
      ahb_if.HREADY = 1'b0; ahb_if.HRESP = 1'b0; ahb_if.HRDATA = $urandom;
      push_exp(1'b1, 1'b0, 1'b0, 5'd12, 32'h0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_stall_req", 32'(w_stall_req_o), 32'd0);
    check("midrst_rf_write", 32'(rf_rd_write_o), 32'd0);
    check("midrst_bus_error", 32'(w_bus_error_o), 32'd0);
    check("midrst_fwd_valid", 32'(x_fwd_valid_o), 32'd0);
    check("midrst_fwd_rd", 32'(x_fwd_rd_o), 32'd0);
    check("midrst_fwd_value", x_fwd_value_o, 32'h0);
    check("midrst_state", 32'(dbg_state_o), 32'd0);
    @(posedge clk_i); #1;
    set_idle();
    ahb_if.HREADY = 1'b0; ahb_if.HRESP = 1'b0;
    rst_i = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b1, 1'b0);
    run_instr(K_LOAD, 5'd13, 1'b1, LDST_HU, 32'h6, 32'hBEEF0001, 1, 1, 1'b0);

    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b1, 1'b0);
    @(negedge clk_i);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
